// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC and fetches from an instruction memory over a req/ack handshake of
// variable latency. Presents {PC, PC+4, instruction, valid} to decode. Supports a
// decode stall and a branch/jump flush. Flush has priority over stall.
//
// Ports:
//   clk             clock, all state updates on posedge
//   rst_n           asynchronous active-low reset
//   stall           decode cannot accept; IF/ID register and PC hold
//   flush           redirect; discard in-flight/held fetch, PC <= inBranchTarget
//   inBranchTarget  redirect address (bits [1:0] ignored)
//   imem_req        fetch request, held until imem_ack
//   imem_addr       fetch address, stable while imem_req=1
//   imem_ack        memory returns imem_rdata this cycle
//   imem_rdata      instruction word, valid with imem_ack
//   outPc           IF/ID: PC of outIns
//   outAdder        IF/ID: outPc + 4
//   outIns          IF/ID: instruction word (NOP_INSTR when outValid=0)
//   outValid        IF/ID: 1 = real instruction, 0 = bubble

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] inBranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] outPc,
  output logic [31:0] outAdder,
  output logic [31:0] outIns,
  output logic        outValid
);

  localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StDrain = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_hold_ins;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_adder;
  logic [31:0] r_out_ins;
  logic        r_out_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;  // wraps modulo 2^32
  assign w_target   = inBranchTarget & ~32'h3;

  // Request is a pure decode of state; gated by rst_n so it is low during reset.
  assign imem_req  = rst_n && (r_state != StHold);
  assign imem_addr = r_addr;

  assign outPc    = r_out_pc;
  assign outAdder = r_out_adder;
  assign outIns   = r_out_ins;
  assign outValid = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFetch;
      r_pc        <= ResetPcAligned;
      r_addr      <= ResetPcAligned;
      r_hold_ins  <= NOP_INSTR;
      r_out_pc    <= 32'h0;
      r_out_adder <= 32'h0;
      r_out_ins   <= NOP_INSTR;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StFetch: begin
          if (flush) begin
            r_pc        <= w_target;
            r_out_valid <= 1'b0;
            r_out_ins   <= NOP_INSTR;
            if (imem_ack) begin
              // Returning word is dropped; next request goes straight to the target.
              r_addr <= w_target;
            end else begin
              // Request cannot be withdrawn: keep the old address until it completes.
              r_state <= StDrain;
            end
          end else if (imem_ack && !stall) begin
            r_out_pc    <= r_pc;
            r_out_adder <= w_pc_plus4;
            r_out_ins   <= imem_rdata;
            r_out_valid <= 1'b1;
            r_pc        <= w_pc_plus4;
            r_addr      <= w_pc_plus4;
          end else if (imem_ack) begin
            r_hold_ins <= imem_rdata;
            r_state    <= StHold;
          end else if (!stall) begin
            r_out_valid <= 1'b0;
            r_out_ins   <= NOP_INSTR;
          end
        end

        StDrain: begin
          if (flush) begin
            r_pc        <= w_target;
            r_out_valid <= 1'b0;
            r_out_ins   <= NOP_INSTR;
            if (imem_ack) begin
              r_state <= StFetch;
              r_addr  <= w_target;
            end
          end else begin
            if (imem_ack) begin
              r_state <= StFetch;
              r_addr  <= r_pc;
            end
            if (!stall) begin
              r_out_valid <= 1'b0;
              r_out_ins   <= NOP_INSTR;
            end
          end
        end

        StHold: begin
          if (flush) begin
            r_pc        <= w_target;
            r_addr      <= w_target;
            r_state     <= StFetch;
            r_out_valid <= 1'b0;
            r_out_ins   <= NOP_INSTR;
          end else if (!stall) begin
            r_out_pc    <= r_pc;
            r_out_adder <= w_pc_plus4;
            r_out_ins   <= r_hold_ins;
            r_out_valid <= 1'b1;
            r_pc        <= w_pc_plus4;
            r_addr      <= w_pc_plus4;
            r_state     <= StFetch;
          end
        end

        default: r_state <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed testbench for fetch_stage with immediate assertions.
// Memory model: imem_rdata is always imem_addr ^ 0xA5A5A5A5; ack is driven by the steps.

module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] Nop     = 32'h0000_0000;
  localparam logic [31:0] Xmask   = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] inBranchTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] outPc;
  logic [31:0] outAdder;
  logic [31:0] outIns;
  logic        outValid;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC (ResetPc),
    .NOP_INSTR(Nop)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .inBranchTarget(inBranchTarget),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .outPc         (outPc),
    .outAdder      (outAdder),
    .outIns        (outIns),
    .outValid      (outValid)
  );

  assign imem_rdata = imem_addr ^ Xmask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Real instruction in IF/ID for address pc.
  task automatic chk_ins(input string tag, input logic [31:0] pc);
    chk({tag, ".pc"}, outPc, pc);
    chk({tag, ".adder"}, outAdder, pc + 32'd4);
    chk({tag, ".ins"}, outIns, pc ^ Xmask);
    chk({tag, ".valid"}, {31'd0, outValid}, 32'd1);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'd0, outValid}, 32'd0);
    chk({tag, ".ins"}, outIns, Nop);
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, outPc, 32'h0);
    chk({tag, ".adder"}, outAdder, 32'h0);
    chk_bubble(tag);
    chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    imem_ack       = 1'b0;
    inBranchTarget = 32'h0;

    // Reset state
    #2;
    chk_reset("reset");
    #6;  // t=8, away from clock edges
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    #1;
    chk_req("first_req", 1'b1, ResetPc);

    // 1: ack every cycle, one instruction per cycle
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ins("t1_stream", ResetPc + 32'(4 * k));
      chk_req("t1_req", 1'b1, ResetPc + 32'(4 * (k + 1)));
    end

    // 2: three non-ack cycles then ack
    imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_bubble("t2_wait");
      chk_req("t2_addr_stable", 1'b1, 32'h0040_000C);
    end
    imem_ack = 1'b1;
    step();
    chk_ins("t2_deliver", 32'h0040_000C);
    chk_req("t2_next", 1'b1, 32'h0040_0010);

    // 3: stall on the ack cycle, held for two cycles
    stall = 1'b1;
    step();
    chk_ins("t3_frozen1", 32'h0040_000C);
    chk_req("t3_noreq1", 1'b0, 32'h0);
    imem_ack = 1'b0;
    step();
    chk_ins("t3_frozen2", 32'h0040_000C);
    chk_req("t3_noreq2", 1'b0, 32'h0);
    stall = 1'b0;
    step();
    chk_ins("t3_held", 32'h0040_0010);
    chk_req("t3_next", 1'b1, 32'h0040_0014);

    // 4: flush with no ack pending -> drain the old request
    flush          = 1'b1;
    inBranchTarget = 32'h0040_0103;
    step();
    flush = 1'b0;
    chk_bubble("t4_flush");
    chk_req("t4_drain1", 1'b1, 32'h0040_0014);
    step();
    chk_bubble("t4_drainwait");
    chk_req("t4_drain2", 1'b1, 32'h0040_0014);
    imem_ack = 1'b1;
    step();
    chk_bubble("t4_dropped");
    chk_req("t4_target", 1'b1, 32'h0040_0100);
    step();
    chk_ins("t4_target_ins", 32'h0040_0100);
    flush          = 1'b1;
    stall          = 1'b1;
    inBranchTarget = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    stall = 1'b0;
    chk_bubble("t4_flush_stall");
    chk_req("t4_redirect", 1'b1, 32'hFFFF_FFFC);

    // 5: PC wrap at 0xFFFFFFFC
    step();
    chk("t5_pc", outPc, 32'hFFFF_FFFC);
    chk("t5_adder", outAdder, 32'h0000_0000);
    chk("t5_ins", outIns, 32'h5A5A_5A59);
    chk("t5_valid", {31'd0, outValid}, 32'd1);
    chk_req("t5_wrap_addr", 1'b1, 32'h0000_0000);

    // 6a: reset mid-DRAIN
    imem_ack       = 1'b0;
    flush          = 1'b1;
    inBranchTarget = 32'h0000_1000;
    step();
    flush = 1'b0;
    chk_req("t6_in_drain", 1'b1, 32'h0000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst_drain");
    #1;
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    #1;
    chk_req("t6_rel_drain", 1'b1, ResetPc);
    step();
    chk_ins("t6_first_after_drain", ResetPc);

    // 6b: reset mid-HOLD
    stall = 1'b1;
    step();
    chk_req("t6_in_hold", 1'b0, 32'h0);
    chk_ins("t6_hold_frozen", ResetPc);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst_hold");
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    chk_req("t6_rel_hold", 1'b1, ResetPc);
    step();
    chk_ins("t6_first_after_hold", ResetPc);
    chk_req("t6_after_hold_next", 1'b1, ResetPc + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
